// File: rtl/permutation_sequencer.sv
// Round sequencer for the ASCON permutation datapath: runs p12, p8 or p6 by
// stepping the round index up to 11 and steering the datapath mux and register enable.
module permutation_sequencer (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  output logic       ready_o,
  output logic       selection_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  state_t     state_q;
  logic [3:0] round_q;
  logic       first_q;
  logic [3:0] first_round;

  // Shorter permutations are the tail of p12; reserved mode falls back to p12.
  always_comb begin
    first_round = 4'd0;
    case (mode_i)
      2'b01:   first_round = 4'd4;
      2'b10:   first_round = 4'd6;
      default: first_round = 4'd0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      round_q  <= 4'd0;
      first_q  <= 1'b0;
      ready_o  <= 1'b1;
      enable_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= RUN;
            round_q  <= first_round;
            first_q  <= 1'b1;
            ready_o  <= 1'b0;
            enable_o <= 1'b1;
            busy_o   <= 1'b1;
          end
        end
        RUN: begin
          first_q <= 1'b0;
          if (round_q == LAST_ROUND) begin
            state_q  <= DONE;
            round_q  <= 4'd0;
            enable_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          round_q  <= 4'd0;
          first_q  <= 1'b0;
          ready_o  <= 1'b1;
          enable_o <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
        end
      endcase
    end
  end

  // round_q is cleared on leaving RUN, so it can drive the round index directly.
  assign round_o     = round_q;
  assign selection_o = enable_o & ~first_q;

endmodule

// File: tb/tb_permutation_sequencer.sv
// Bench for permutation_sequencer: a queue of expected per-cycle outputs plus a
// behavioural ASCON datapath whose final state is compared with a direct permutation.
module tb_permutation_sequencer;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [1:0] mode_i;
  logic       ready_o;
  logic       selection_o;
  logic       enable_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  always #5 clock_i = ~clock_i;

  permutation_sequencer dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .ready_o     (ready_o),
    .selection_o (selection_o),
    .enable_o    (enable_o),
    .round_o     (round_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int checks = 0;
  int errors = 0;

  // Expected output vector layout: {ready, selection, enable, busy, done, round[3:0]}
  localparam logic [8:0] IDLE_V = 9'b1_0000_0000;
  logic [8:0]   exp_q[$];
  logic [319:0] ext_in;
  logic [319:0] dp_q;
  logic [319:0] ref_q;
  logic         use_zero;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [3:0]  hi;
    {x0, x1, x2, x3, x4} = s;
    hi = 4'hf - r;
    x2 = x2 ^ {56'd0, hi, r};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
    logic [319:0] v;
    v = s;
    for (int i = 12 - nr; i < 12; i++) v = round_fn(v, 4'(i));
    return v;
  endfunction

  function automatic int rounds_for(input logic [1:0] md);
    case (md)
      2'b01:   return 8;
      2'b10:   return 6;
      default: return 12;
    endcase
  endfunction

  // Behavioural datapath: input mux, round function, state register.
  always_ff @(posedge clock_i)
    if (enable_o) dp_q <= round_fn(selection_o ? dp_q : ext_in, round_o);

  task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic st, input logic [1:0] md, input logic rs);
    logic [8:0] e;
    logic       was_idle;
    int         nr;
    was_idle = (exp_q.size() == 0);
    e = was_idle ? IDLE_V : exp_q.pop_front();
    check_eq("outs", 320'({ready_o, selection_o, enable_o, busy_o, done_o, round_o}), 320'(e));
    if (e[4]) check_eq("dp_state", dp_q, ref_q);
    if (was_idle) ext_in = use_zero ? 320'd0 :
      {$urandom, $urandom, $urandom, $urandom, $urandom,
       $urandom, $urandom, $urandom, $urandom, $urandom};
    start_i = st;
    mode_i  = md;
    reset_i = rs;
    if (rs) begin
      exp_q.delete();
    end else if (was_idle && st) begin
      nr = rounds_for(md);
      for (int r = 12 - nr; r < 12; r++)
        exp_q.push_back({1'b0, (r != 12 - nr), 1'b1, 1'b1, 1'b0, 4'(r)});
      exp_q.push_back(9'b0_0001_0000);
      ref_q = perm(ext_in, nr);
    end
    @(negedge clock_i);
  endtask

  initial begin
    int n;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    mode_i   = 2'b00;
    ext_in   = '0;
    use_zero = 1'b1;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);

    // p12 from the all-zero state, then p8, p6 and the reserved mode
    cycle(1'b1, 2'b00, 1'b0);
    repeat (14) cycle(1'b0, 2'b00, 1'b0);
    use_zero = 1'b0;
    cycle(1'b1, 2'b01, 1'b0);
    repeat (10) cycle(1'b0, 2'b00, 1'b0);
    cycle(1'b1, 2'b10, 1'b0);
    repeat (8) cycle(1'b0, 2'b00, 1'b0);
    cycle(1'b1, 2'b11, 1'b0);
    repeat (14) cycle(1'b0, 2'b00, 1'b0);

    // start held high with mode toggling during a p6 run
    cycle(1'b1, 2'b10, 1'b0);
    repeat (20) cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    repeat (14) cycle(1'b0, 2'b00, 1'b0);

    // reset at round 5 of a p12 run
    cycle(1'b1, 2'b00, 1'b0);
    n = 0;
    while (!(exp_q.size() > 0 && exp_q[0][3:0] == 4'd5 && exp_q[0][5]) && n < 20) begin
      cycle(1'b0, 2'b00, 1'b0);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL reach_round5: waited %0d cycles, required under 20", n);
    end
    cycle(1'b0, 2'b00, 1'b1);
    repeat (16) cycle(1'b0, 2'b00, 1'b0);

    // reset and start on the same edge
    cycle(1'b1, 2'b00, 1'b1);
    repeat (3) cycle(1'b0, 2'b00, 1'b0);

    // random traffic with occasional resets
    repeat (600)
      cycle(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 40) == 0));
    repeat (15) cycle(1'b0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/permutation_sequencer.md
# permutation_sequencer

Control initiator for the ASCON permutation datapath (input mux, round function, state register). It accepts a start request with a round-count mode and drives the datapath's select, register-enable and round-index inputs for p12, p8 or p6. It signals completion when the permuted state is valid in the datapath state register. It sits between the top-level ASCON mode FSM (initialisation, associated data, plaintext, finalisation phases) and the permutation datapath.

## Interface
Parameters:
- none; the round count is fixed by the ASCON specification at 12 rounds, indices 0..11.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  reset; one clock; reset is synchronous and active-high.
- start_i  in  1  start request; accepted only when ready_o=1.
- mode_i  in  2  sampled on acceptance:
  - 00 = p12, first round 0.
  - 01 = p8, first round 4.
  - 10 = p6, first round 6.
  - 11 = reserved; treated as p12.
- ready_o  out  1  sequencer idle; a start is accepted this cycle if start_i=1.
- selection_o  out  1  datapath mux select:
  - 0 = external state in, on the first round only.
  - 1 = register feedback.
- enable_o  out  1  datapath state-register enable; 1 in every round cycle.
- round_o  out  4  round index to the round-constant logic, range 0..11.
- busy_o  out  1  permutation in progress.
- done_o  out  1  one-cycle pulse; the datapath register holds the final state this cycle.

## Operation
- States:
  - IDLE: ready_o=1, all other outputs 0.
  - RUN: enable_o=1, busy_o=1.
  - DONE: done_o=1.
- All outputs are decoded from state flops only; there are no combinational paths from inputs to outputs.
- Internal registers:
  - round_q (4 bit).
  - first_q (1 bit).
- IDLE -> RUN on an edge with start_i=1:
  - round_q <= first round taken from mode_i.
  - first_q <= 1.
- RUN outputs:
  - round_o = round_q.
  - selection_o = ~first_q.
  - enable_o = 1.
- RUN, each edge:
  - first_q <= 0.
  - If round_q == 11: go to DONE and set round_q <= 0.
  - Otherwise: round_q <= round_q + 1.
- DONE -> IDLE unconditionally after one cycle. start_i is ignored in DONE.
- start_i is ignored in RUN and DONE. It is not queued, and mode_i changes in those states have no effect.
- round_q never exceeds 11. There is no wrap-around; reaching 11 always terminates the run.
- round_o = 0 whenever the state is not RUN.

## Timing
- Reset:
  - An edge with reset_i=1 forces IDLE, round_q=0, first_q=0, regardless of current state, including mid-RUN.
  - reset_i has priority over start_i.
  - In the cycle after the reset edge: ready_o=1, and busy_o, done_o, enable_o, selection_o and round_o are all 0.
  - A permutation aborted by reset produces no done_o.
- Latency, with edge E0 = start accepted:
  - p12: 12 RUN cycles after E0, then done_o high during cycle 13.
  - p8: 8 RUN cycles, done_o in cycle 9.
  - p6: 6 RUN cycles, done_o in cycle 7.
- The first RUN cycle has selection_o=0 and enable_o=1. The datapath loads p(external state) at the end of that cycle.
- The next start is accepted at the earliest in the cycle after DONE (IDLE). Minimum issue interval: p12 = 14 cycles, p8 = 10, p6 = 8.
- Back-to-back: if start_i is held high, the next run begins on the edge ending the first IDLE cycle after DONE.

## Test plan
- Reset then p12:
  - Stimulus: assert reset_i 2 cycles, then pulse start_i with mode_i=00.
  - Required: ready_o=1 after reset; round_o=0,1,..,11 over 12 cycles; selection_o=0 only in the first cycle; enable_o=1 for all 12 cycles; done_o=1 exactly in cycle 13; ready_o=1 in cycle 14.
- p8 and p6:
  - mode_i=01: round_o=4..11, done_o in cycle 9.
  - mode_i=10: round_o=6..11, done_o in cycle 7.
  - mode_i=11: identical to p12.
- Start and mode changes while busy:
  - Stimulus: hold start_i=1 and toggle mode_i during a p6 run.
  - Required: no effect on the run; the second run starts in the cycle after DONE+IDLE with mode_i as sampled then.
- Reset mid-run:
  - Stimulus: assert reset_i at round_o=5 of a p12 run.
  - Required: next cycle IDLE, round_o=0, enable_o=0; no done_o pulse ever appears for that run.
- Reset and start coincident:
  - Stimulus: reset_i=1 and start_i=1 on the same edge.
  - Required: remains IDLE, busy_o=0.
- Datapath integration:
  - Stimulus: drive the permutation datapath with this block from the all-zero state under p12.
  - Required: the state register output during done_o equals the ASCON reference-model p12 result.
